// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and helpers for the memory arbiter.
//   mem_arb_state_t : arbiter FSM encoding (IDLE, ACCESS, DONE)
//   ptr_width()     : round-robin pointer width, $clog2(n) but never below 1
package mem_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } mem_arb_state_t;

    function automatic int ptr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mem_arb_picker.sv
// mem_arb_picker: combinational rotated-priority search.
//   req   in  N_ACCESSORS  pending request vector
//   ptr   in  PTR_W        index with highest priority
//   found out 1            at least one request pending
//   grant out PTR_W        winning index
// Build option: MEM_ARB_FIXED_PRIO_EN makes the search start at index 0
// regardless of ptr (lowest index wins).
module mem_arb_picker
    import mem_arb_pkg::*;
#(
    parameter int N_ACCESSORS = 2,
    parameter int PTR_W       = ptr_width(N_ACCESSORS)
) (
    input  logic [N_ACCESSORS-1:0] req,
    input  logic [PTR_W-1:0]       ptr,
    output logic                   found,
    output logic [PTR_W-1:0]       grant
);

    // One extra bit so base + offset cannot overflow before the modulo wrap.
    logic [PTR_W:0] base;
    logic [PTR_W:0] cand;

`ifdef MEM_ARB_FIXED_PRIO_EN
    logic unused_ptr;
    assign unused_ptr = ^ptr;
    assign base = '0;
`else
    assign base = {1'b0, ptr};
`endif

    // Walk offsets from farthest to nearest so the last hit is the one
    // closest to the pointer.
    always_comb begin
        found = 1'b0;
        grant = '0;
        cand  = '0;
        for (int i = N_ACCESSORS - 1; i >= 0; i--) begin
            cand = base + (PTR_W+1)'(i);
            if (cand >= (PTR_W+1)'(N_ACCESSORS)) begin
                cand = cand - (PTR_W+1)'(N_ACCESSORS);
            end
            if (req[cand[PTR_W-1:0]]) begin
                found = 1'b1;
                grant = cand[PTR_W-1:0];
            end
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port memory between N_ACCESSORS requesters,
// one transaction at a time, round-robin by default.
//   clk, reset_i       clock / synchronous active-high reset
//   acc_address_i      per-accessor address, slice k = [k*BITSIZE +: BITSIZE]
//   acc_load_i/store_i per-accessor request levels (store wins over load)
//   acc_data_i         per-accessor write data
//   acc_data_o         per-accessor read data, holds last value read
//   acc_done_o         one-cycle completion pulse per accessor
//   mem_req_o/we_o/addr_o/wdata_o  memory request fields
//   mem_rdata_i/ack_i  memory response
// Build option: MEM_ARB_FIXED_PRIO_EN selects fixed priority (index 0 wins)
// and removes the round-robin pointer register.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_IDLE   | waiting; latch winner's fields when any request pending
// ST_ACCESS | mem_req_o high until mem_ack_i; read data captured on ack
// ST_DONE   | done pulse to granted accessor, request gap cycle
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int BITSIZE     = 32,
    parameter int N_ACCESSORS = 2
) (
    input  logic                           clk,
    input  logic                           reset_i,
    input  logic [N_ACCESSORS*BITSIZE-1:0] acc_address_i,
    input  logic [N_ACCESSORS-1:0]         acc_load_i,
    input  logic [N_ACCESSORS-1:0]         acc_store_i,
    input  logic [N_ACCESSORS*BITSIZE-1:0] acc_data_i,
    output logic [N_ACCESSORS*BITSIZE-1:0] acc_data_o,
    output logic [N_ACCESSORS-1:0]         acc_done_o,
    output logic                           mem_req_o,
    output logic                           mem_we_o,
    output logic [BITSIZE-1:0]             mem_addr_o,
    output logic [BITSIZE-1:0]             mem_wdata_o,
    input  logic [BITSIZE-1:0]             mem_rdata_i,
    input  logic                           mem_ack_i
);

    localparam int PTR_W = ptr_width(N_ACCESSORS);

    mem_arb_state_t state, state_next;

    logic [PTR_W-1:0]               ptr;
    logic [PTR_W-1:0]               grant;
    logic [PTR_W-1:0]               pick_grant;
    logic                           pick_found;
    logic [N_ACCESSORS-1:0]         req;
    logic [BITSIZE-1:0]             sel_addr;
    logic [BITSIZE-1:0]             sel_wdata;
    logic                           sel_store;
    logic [N_ACCESSORS*BITSIZE-1:0] acc_data;
    logic                           ack_hit;

    assign req        = acc_load_i | acc_store_i;
    assign acc_data_o = acc_data;
    assign ack_hit    = (state == ST_ACCESS) && mem_ack_i;

    mem_arb_picker #(
        .N_ACCESSORS (N_ACCESSORS),
        .PTR_W       (PTR_W)
    ) u_picker (
        .req   (req),
        .ptr   (ptr),
        .found (pick_found),
        .grant (pick_grant)
    );

    always_comb begin
        sel_addr  = '0;
        sel_wdata = '0;
        sel_store = 1'b0;
        for (int k = 0; k < N_ACCESSORS; k++) begin
            if (pick_grant == PTR_W'(k)) begin
                sel_addr  = acc_address_i[k*BITSIZE +: BITSIZE];
                sel_wdata = acc_data_i[k*BITSIZE +: BITSIZE];
                sel_store = acc_store_i[k];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset_i) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        mem_req_o  = 1'b0;
        acc_done_o = '0;
        case (state)
            ST_IDLE: begin
                if (pick_found) begin
                    state_next = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                mem_req_o = 1'b1;
                if (mem_ack_i) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                state_next = ST_IDLE;
                for (int k = 0; k < N_ACCESSORS; k++) begin
                    if (grant == PTR_W'(k)) begin
                        acc_done_o[k] = 1'b1;
                    end
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset_i) begin
            grant       <= '0;
            mem_we_o    <= 1'b0;
            mem_addr_o  <= '0;
            mem_wdata_o <= '0;
            acc_data    <= '0;
        end else begin
            if (state == ST_IDLE && pick_found) begin
                grant       <= pick_grant;
                mem_we_o    <= sel_store;
                mem_addr_o  <= sel_addr;
                mem_wdata_o <= sel_wdata;
            end
            // Read data lands on the same edge that enters DONE, so it is
            // valid together with the done pulse.
            if (ack_hit && !mem_we_o) begin
                for (int k = 0; k < N_ACCESSORS; k++) begin
                    if (grant == PTR_W'(k)) begin
                        acc_data[k*BITSIZE +: BITSIZE] <= mem_rdata_i;
                    end
                end
            end
        end
    end

`ifdef MEM_ARB_FIXED_PRIO_EN
    assign ptr = '0;
`else
    localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(N_ACCESSORS - 1);

    // Pointer only moves on a completed transaction; an abandoned one
    // (reset mid-access) leaves no trace.
    always_ff @(posedge clk) begin
        if (reset_i) begin
            ptr <= '0;
        end else if (ack_hit) begin
            ptr <= (grant == LAST_IDX) ? '0 : grant + PTR_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

    localparam int BW = 32;
    localparam int NA = 2;

    logic             clk = 1'b0;
    logic             reset;
    logic [NA*BW-1:0] acc_address;
    logic [NA-1:0]    acc_load;
    logic [NA-1:0]    acc_store;
    logic [NA*BW-1:0] acc_data_in;
    logic [NA*BW-1:0] acc_data_out;
    logic [NA-1:0]    acc_done;
    logic             mem_req;
    logic             mem_we;
    logic [BW-1:0]    mem_addr;
    logic [BW-1:0]    mem_wdata;
    logic [BW-1:0]    mem_rdata;
    logic             mem_ack;

    mem_arbiter #(.BITSIZE(BW), .N_ACCESSORS(NA)) dut (
        .clk           (clk),
        .reset_i       (reset),
        .acc_address_i (acc_address),
        .acc_load_i    (acc_load),
        .acc_store_i   (acc_store),
        .acc_data_i    (acc_data_in),
        .acc_data_o    (acc_data_out),
        .acc_done_o    (acc_done),
        .mem_req_o     (mem_req),
        .mem_we_o      (mem_we),
        .mem_addr_o    (mem_addr),
        .mem_wdata_o   (mem_wdata),
        .mem_rdata_i   (mem_rdata),
        .mem_ack_i     (mem_ack)
    );

    always #5 clk = ~clk;

    // Memory contents are a fixed function of the address.
    function automatic logic [31:0] mem_model(input logic [31:0] a);
        return a ^ 32'hDEADBEFF;
    endfunction

    assign mem_rdata = mem_model(mem_addr);

    typedef struct {
        int          acc;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [1:0]  done;
        logic [63:0] data;
    } txn_t;

    typedef struct {
        int          acc;
        bit          ld;
        bit          st;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          ack_delay;
        logic        exp_we;
        logic [1:0]  exp_done;
        int          exp_len;
    } vec_t;

    txn_t        exp_q[$];
    int          n_checks = 0;
    int          n_fail = 0;
    logic [63:0] shadow = '0;
    int          ptr_model = 0;
    int          cyc = 0;
    int          last_done_cyc = -1;
    int          req_run = 0;
    int          last_len = 0;
    bit          chk_spacing = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name, input int act, input int exp);
        n_checks++;
        n_fail++;
        $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic push_txn(input int acc, input logic we, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic [1:0] done, input bit completes);
        txn_t t;
        if (!we && completes) shadow[acc*32 +: 32] = mem_model(addr);
        t.acc   = acc;
        t.we    = we;
        t.addr  = addr;
        t.wdata = wdata;
        t.done  = done;
        t.data  = shadow;
        exp_q.push_back(t);
        if (completes) begin
`ifdef MEM_ARB_FIXED_PRIO_EN
            ptr_model = 0;
`else
            ptr_model = (acc + 1) % NA;
`endif
        end
    endtask

    // Scoreboard monitor: request fields checked every ACCESS cycle,
    // expectations popped on each done pulse.
    always @(posedge clk) begin
        #1;
        cyc++;
        if (mem_req === 1'b1) begin
            req_run++;
            if (exp_q.size() == 0) begin
                fail_now("unexpected_req", 1, 0);
            end else begin
                check("req_addr", 64'(mem_addr), 64'(exp_q[0].addr));
                check("req_we", 64'(mem_we), 64'(exp_q[0].we));
                check("req_wdata", 64'(mem_wdata), 64'(exp_q[0].wdata));
            end
        end else if (req_run > 0) begin
            last_len = req_run;
            req_run  = 0;
        end
        if (acc_done !== 2'b00) begin
            if (exp_q.size() == 0) begin
                fail_now("unexpected_done", int'(acc_done), 0);
            end else begin
                check("done_vec", 64'(acc_done), 64'(exp_q[0].done));
                check("acc_data", acc_data_out, exp_q[0].data);
                if (chk_spacing && last_done_cyc >= 0)
                    check("done_spacing", 64'(cyc - last_done_cyc), 64'd3);
                last_done_cyc = cyc;
                void'(exp_q.pop_front());
            end
        end
    end

    task automatic wait_drain(input string name);
        int budget = 0;
        while (exp_q.size() != 0 && budget < 60) begin
            @(negedge clk);
            budget++;
        end
        if (exp_q.size() != 0) begin
            fail_now({name, "_drain_pending"}, exp_q.size(), 0);
            exp_q.delete();
        end
    endtask

    task automatic wait_req(input string name, output bit seen);
        int budget = 0;
        while (mem_req !== 1'b1 && budget < 20) begin
            @(negedge clk);
            budget++;
        end
        seen = (mem_req === 1'b1);
        if (!seen) fail_now({name, "_req_timeout"}, 0, 1);
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        bit seen;
        @(negedge clk);
        acc_load    = '0;
        acc_store   = '0;
        acc_address = {32'hBAD1_0000 + 32'(idx), 32'hBAD0_0000 + 32'(idx)};
        acc_data_in = {32'hCAFE_1111, 32'hCAFE_0000};
        acc_address[v.acc*32 +: 32] = v.addr;
        acc_data_in[v.acc*32 +: 32] = v.wdata;
        acc_load[v.acc]  = v.ld;
        acc_store[v.acc] = v.st;
        mem_ack = (v.ack_delay == 0);
        push_txn(v.acc, v.exp_we, v.addr, v.wdata, v.exp_done, 1'b1);
        wait_req("vec", seen);
        if (seen && v.ack_delay > 0) begin
            repeat (v.ack_delay) @(negedge clk);
            mem_ack = 1'b1;
        end
        wait_drain("vec");
        acc_load  = '0;
        acc_store = '0;
        mem_ack   = 1'b0;
        check("req_len", 64'(last_len), 64'(v.exp_len));
        repeat (2) @(negedge clk);
    endtask

    // Both accessors hold loads; ack held high. Called at a negedge.
    task automatic contention(input int n, input string name);
        int g;
        acc_address = {32'h0000_0200, 32'h0000_0100};
        acc_data_in = {32'h1111_2222, 32'h3333_4444};
        acc_load    = 2'b11;
        acc_store   = 2'b00;
        mem_ack     = 1'b1;
        chk_spacing   = 1'b1;
        last_done_cyc = -1;
        for (int i = 0; i < n; i++) begin
            g = ptr_model;
            push_txn(g, 1'b0, acc_address[g*32 +: 32], acc_data_in[g*32 +: 32],
                     2'(1 << g), 1'b1);
        end
        wait_drain(name);
        acc_load    = '0;
        mem_ack     = 1'b0;
        chk_spacing = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        vec_t vecs[6];
        bit   seen;

        vecs[0] = '{1, 1'b1, 1'b0, 32'h0000_0010, 32'h0000_0000, 0, 1'b0, 2'b10, 1};
        vecs[1] = '{0, 1'b1, 1'b0, 32'h0000_0020, 32'h0000_0077, 0, 1'b0, 2'b01, 1};
        vecs[2] = '{0, 1'b1, 1'b1, 32'h0000_0004, 32'h0000_0055, 0, 1'b1, 2'b01, 1};
        vecs[3] = '{1, 1'b0, 1'b1, 32'h0000_0008, 32'h0000_1234, 5, 1'b1, 2'b10, 6};
        vecs[4] = '{1, 1'b1, 1'b0, 32'hFFFF_FFFC, 32'h0000_000A, 2, 1'b0, 2'b10, 3};
        vecs[5] = '{0, 1'b0, 1'b1, 32'h0000_0000, 32'hFFFF_FFFF, 1, 1'b1, 2'b01, 2};

        reset       = 1'b1;
        acc_address = '0;
        acc_load    = '0;
        acc_store   = '0;
        acc_data_in = '0;
        mem_ack     = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_req", 64'(mem_req), 64'd0);
        check("rst_we", 64'(mem_we), 64'd0);
        check("rst_addr", 64'(mem_addr), 64'd0);
        check("rst_wdata", 64'(mem_wdata), 64'd0);
        check("rst_data", acc_data_out, 64'd0);
        check("rst_done", 64'(acc_done), 64'd0);
        reset = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 6; i++) run_vec(vecs[i], i);

        // Reset while the memory withholds ack.
        @(negedge clk);
        acc_address = {32'h0000_0030, 32'h0000_0BAD};
        acc_data_in = {32'h0000_0099, 32'h0000_0000};
        acc_load    = 2'b10;
        acc_store   = 2'b00;
        mem_ack     = 1'b0;
        push_txn(1, 1'b0, 32'h0000_0030, 32'h0000_0099, 2'b10, 1'b0);
        wait_req("rst_mid", seen);
        if (seen) begin
            repeat (2) @(negedge clk);
            reset = 1'b1;
            @(negedge clk);
            check("rst_mid_req", 64'(mem_req), 64'd0);
            check("rst_mid_done", 64'(acc_done), 64'd0);
            check("rst_mid_data", acc_data_out, 64'd0);
        end
        exp_q.delete();
        shadow    = '0;
        ptr_model = 0;
        reset     = 1'b0;
        contention(2, "post_reset");

        contention(6, "contention");

        repeat (4) @(negedge clk);
        check("final_idle_req", 64'(mem_req), 64'd0);
        check("final_queue", 64'(exp_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
